// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults for the multi-port register file.
// Holds the default geometry, the stack-pointer placement and reset value,
// and the index of the hardwired zero register.
package regfile_pkg;

  localparam int              RF_DATA_W  = 32;
  localparam int              RF_ADDR_W  = 5;
  localparam int              RF_NUM_RD  = 2;
  localparam int              RF_NUM_WR  = 1;
  localparam int              RF_SP_IDX  = 29;
  localparam logic [31:0]     RF_SP_INIT = 32'h0000_00FC;

  // Register that always reads as zero and can never be written or reserved.
  localparam int              ZERO_IDX   = 0;

endpackage : regfile_pkg

// File: rtl/regfile_bypass_mux.sv
// regfile_bypass_mux: write-first value selection for one read address.
// Ports:
//   addr    - address being read
//   stored  - current stored value of reg[addr]
//   wr_en   - write enables of all write ports (packed)
//   wr_addr - write addresses of all write ports (packed, ADDR_W each)
//   wr_data - write data of all write ports (packed, DATA_W each)
//   value   - same-cycle winning write data if it targets addr, else stored;
//             always zero for the zero register
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_WR = RF_NUM_WR
) (
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        stored,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        value
);

  logic [DATA_W-1:0] sel_s;
  logic              hit_s;

  // Scan ports low to high so a later (higher-index) hit overrides earlier ones.
  always_comb begin
    sel_s = stored;
    hit_s = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      hit_s = wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] == addr);
      sel_s = hit_s ? wr_data[i*DATA_W +: DATA_W] : sel_s;
    end
  end

  // The zero register masks any bypassed write.
  always_comb begin
    if (addr == ADDR_W'(ZERO_IDX)) begin
      value = {DATA_W{1'b0}};
    end else begin
      value = sel_s;
    end
  end

endmodule : regfile_bypass_mux

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with write-first bypass,
// hardwired zero register, per-register busy (reservation) tracking and a
// debug read port.
// Ports:
//   clock, reset        - single clock; asynchronous active-high reset
//   rd_addr / rd_data   - NUM_RD packed read ports, 1-cycle registered data
//   rd_busy             - registered post-update busy bit per read port
//   wr_en/addr/data     - NUM_WR packed write ports, higher index wins
//   rsv_en / rsv_addr   - mark one register as pending a write
//   dbg_req / dbg_addr  - debug read request, accepted every cycle
//   dbg_data / dbg_valid- debug read result, valid one cycle after request
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int              DATA_W  = RF_DATA_W,
  parameter int              ADDR_W  = RF_ADDR_W,
  parameter int              NUM_RD  = RF_NUM_RD,
  parameter int              NUM_WR  = RF_NUM_WR,
  parameter int              SP_IDX  = RF_SP_IDX,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(RF_SP_INIT)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     dbg_req,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic                     dbg_valid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]        regs_r [DEPTH];
  logic [DEPTH-1:0]         busy_r;
  logic [DEPTH-1:0]         busy_nxt_s;
  logic [NUM_RD*DATA_W-1:0] rd_wf_s;
  logic [DATA_W-1:0]        dbg_wf_s;
  logic [NUM_RD*DATA_W-1:0] rd_data_r;
  logic [NUM_RD-1:0]        rd_busy_r;
  logic [DATA_W-1:0]        dbg_data_r;
  logic                     dbg_valid_r;

  // One-hot decode of a register index.
  function automatic logic [DEPTH-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [DEPTH-1:0] v;
    v    = {DEPTH{1'b0}};
    v[a] = 1'b1;
    return v;
  endfunction

  // Write-first value for every read port.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_bypass_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_rd_mux (
      .addr    (rd_addr[k*ADDR_W +: ADDR_W]),
      .stored  (regs_r[rd_addr[k*ADDR_W +: ADDR_W]]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .value   (rd_wf_s[k*DATA_W +: DATA_W])
    );
  end

  // Write-first value for the debug port.
  regfile_bypass_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR)
  ) u_dbg_mux (
    .addr    (dbg_addr),
    .stored  (regs_r[dbg_addr]),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .value   (dbg_wf_s)
  );

  // Next busy vector: writes clear, then the reservation sets, so a
  // same-cycle reserve of a written register leaves it busy.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 0; i < NUM_WR; i++) begin
      busy_nxt_s = busy_nxt_s &
                   ~(wr_en[i] ? onehot(wr_addr[i*ADDR_W +: ADDR_W]) : {DEPTH{1'b0}});
    end
    busy_nxt_s = busy_nxt_s | (rsv_en ? onehot(rsv_addr) : {DEPTH{1'b0}});
    busy_nxt_s[ZERO_IDX] = 1'b0;
  end

  // Storage array; later ports are applied last so the highest index wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= (i == SP_IDX) ? SP_INIT : {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_IDX))) begin
          regs_r[wr_addr[i*ADDR_W +: ADDR_W]] <= wr_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Busy bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Registered read data and busy flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_r <= {(NUM_RD*DATA_W){1'b0}};
      rd_busy_r <= {NUM_RD{1'b0}};
    end else begin
      rd_data_r <= rd_wf_s;
      for (int k = 0; k < NUM_RD; k++) begin
        rd_busy_r[k] <= busy_nxt_s[rd_addr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  // Debug port: data holds when no request, valid pulses per request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dbg_data_r  <= {DATA_W{1'b0}};
      dbg_valid_r <= 1'b0;
    end else if (dbg_req) begin
      dbg_data_r  <= dbg_wf_s;
      dbg_valid_r <= 1'b1;
    end else begin
      dbg_valid_r <= 1'b0;
    end
  end

  assign rd_data   = rd_data_r;
  assign rd_busy   = rd_busy_r;
  assign dbg_data  = dbg_data_r;
  assign dbg_valid = dbg_valid_r;

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp with two read
// ports and two write ports.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic              clock;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic              dbg_req;
  logic [AW-1:0]     dbg_addr;
  logic [DW-1:0]     dbg_data;
  logic              dbg_valid;

  int tests_run;
  int tests_failed;

  regfile_mp #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .NUM_RD  (NR),
    .NUM_WR  (NW),
    .SP_IDX  (29),
    .SP_INIT (32'h0000_00FC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_valid (dbg_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    dbg_req  = 1'b0;
    dbg_addr = '0;
  endtask

  task automatic test_reset();
    // Build up state: r5 written and reserved, debug valid.
    idle();
    wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'h0000_0077;
    rsv_en = 1'b1; rsv_addr = 5'd5;
    rd_addr[4:0] = 5'd5; rd_addr[9:5] = 5'd0;
    dbg_req = 1'b1; dbg_addr = 5'd5;
    tick();
    tests_run++;
    if (rd_data[31:0] !== 32'h0000_0077) begin
      tests_failed++; $display("FAIL pre_reset_data: got %h expected %h", rd_data[31:0], 32'h0000_0077);
    end
    tests_run++;
    if (rd_busy[0] !== 1'b1 || dbg_valid !== 1'b1) begin
      tests_failed++; $display("FAIL pre_reset_flags: got busy=%b valid=%b expected 1 1", rd_busy[0], dbg_valid);
    end
    // Mid-cycle reset pulse, checked before any clock edge.
    #3;
    reset = 1'b1;
    #1;
    tests_run++;
    if (rd_busy !== 2'b00 || dbg_valid !== 1'b0 || rd_data !== 64'h0) begin
      tests_failed++; $display("FAIL reset_async: got busy=%b valid=%b data=%h expected 0 0 0", rd_busy, dbg_valid, rd_data);
    end
    idle();
    #1;
    reset = 1'b0;
    rd_addr[4:0] = 5'd0; rd_addr[9:5] = 5'd5;
    dbg_req = 1'b1; dbg_addr = 5'd29;
    tick();
    tests_run++;
    if (rd_data[31:0] !== 32'h0 || rd_data[63:32] !== 32'h0) begin
      tests_failed++; $display("FAIL reset_r0_r5: got %h expected 0", rd_data);
    end
    tests_run++;
    if (rd_busy !== 2'b00) begin
      tests_failed++; $display("FAIL reset_busy: got %b expected 00", rd_busy);
    end
    tests_run++;
    if (dbg_valid !== 1'b1 || dbg_data !== 32'h0000_00FC) begin
      tests_failed++; $display("FAIL reset_sp_dbg: got valid=%b data=%h expected 1 000000fc", dbg_valid, dbg_data);
    end
    idle();
    rd_addr[4:0] = 5'd29;
    tick();
    tests_run++;
    if (rd_data[31:0] !== 32'h0000_00FC) begin
      tests_failed++; $display("FAIL reset_sp_rd: got %h expected 000000fc", rd_data[31:0]);
    end
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 2'b01; wr_addr[4:0] = 5'd7; wr_data[31:0] = 32'hDEAD_BEEF;
    rd_addr[9:5] = 5'd7;
    tick();
    tests_run++;
    if (rd_data[63:32] !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL bypass_same_edge: got %h expected deadbeef", rd_data[63:32]);
    end
    idle();
    tick();
    tests_run++;
    if (rd_data[63:32] !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL bypass_stored: got %h expected deadbeef", rd_data[63:32]);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    wr_en = 2'b01; wr_addr[4:0] = 5'd0; wr_data[31:0] = 32'h0000_1234;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    rd_addr[4:0] = 5'd0; rd_addr[9:5] = 5'd0;
    tick();
    tests_run++;
    if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
      tests_failed++; $display("FAIL zero_same_edge: got data=%h busy=%b expected 0 00", rd_data, rd_busy);
    end
    idle();
    tick();
    tests_run++;
    if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
      tests_failed++; $display("FAIL zero_stored: got data=%h busy=%b expected 0 0", rd_data[31:0], rd_busy[0]);
    end
  endtask

  task automatic test_reservation();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd3;
    rd_addr[4:0] = 5'd3;
    tick();
    tests_run++;
    if (rd_busy[0] !== 1'b1) begin
      tests_failed++; $display("FAIL rsv_set: got busy=%b expected 1", rd_busy[0]);
    end
    idle();
    tick();
    tests_run++;
    if (rd_busy[0] !== 1'b1) begin
      tests_failed++; $display("FAIL rsv_hold: got busy=%b expected 1", rd_busy[0]);
    end
    wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'h0000_0055;
    tick();
    tests_run++;
    if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h0000_0055) begin
      tests_failed++; $display("FAIL rsv_clear: got busy=%b data=%h expected 0 00000055", rd_busy[0], rd_data[31:0]);
    end
    rsv_en = 1'b1; rsv_addr = 5'd3; wr_data[31:0] = 32'h0000_0066;
    tick();
    tests_run++;
    if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h0000_0066) begin
      tests_failed++; $display("FAIL rsv_and_write: got busy=%b data=%h expected 1 00000066", rd_busy[0], rd_data[31:0]);
    end
    idle();
    tick();
    tests_run++;
    if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h0000_0066) begin
      tests_failed++; $display("FAIL rsv_and_write_stored: got busy=%b data=%h expected 1 00000066", rd_busy[0], rd_data[31:0]);
    end
  endtask

  task automatic test_write_priority();
    idle();
    wr_en = 2'b11;
    wr_addr[4:0] = 5'd9; wr_data[31:0]  = 32'h0000_00AA;
    wr_addr[9:5] = 5'd9; wr_data[63:32] = 32'h0000_00BB;
    rd_addr[4:0] = 5'd9; rd_addr[9:5] = 5'd7;
    tick();
    tests_run++;
    if (rd_data[31:0] !== 32'h0000_00BB || rd_data[63:32] !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL prio_bypass: got %h expected deadbeef000000bb", rd_data);
    end
    idle();
    tick();
    tests_run++;
    if (rd_data[31:0] !== 32'h0000_00BB) begin
      tests_failed++; $display("FAIL prio_stored: got %h expected 000000bb", rd_data[31:0]);
    end
    // Different addresses on both ports: each lands independently.
    wr_en = 2'b11;
    wr_addr[4:0] = 5'd10; wr_data[31:0]  = 32'h1111_0000;
    wr_addr[9:5] = 5'd11; wr_data[63:32] = 32'h2222_0000;
    tick();
    idle();
    rd_addr[4:0] = 5'd10; rd_addr[9:5] = 5'd11;
    tick();
    tests_run++;
    if (rd_data !== 64'h2222_0000_1111_0000) begin
      tests_failed++; $display("FAIL dual_write: got %h expected 2222000011110000", rd_data);
    end
  endtask

  task automatic test_debug();
    logic [DW-1:0] exp_d [3];
    logic [AW-1:0] adr   [3];
    exp_d[0] = 32'h0000_00FC; exp_d[1] = 32'hDEAD_BEEF; exp_d[2] = 32'h0;
    adr[0]   = 5'd29;         adr[1]   = 5'd7;          adr[2]   = 5'd0;
    idle();
    tests_run++;
    if (dbg_valid !== 1'b0) begin
      tests_failed++; $display("FAIL dbg_idle: got valid=%b expected 0", dbg_valid);
    end
    for (int i = 0; i < 3; i++) begin
      dbg_req = 1'b1; dbg_addr = adr[i];
      tick();
      tests_run++;
      if (dbg_valid !== 1'b1 || dbg_data !== exp_d[i]) begin
        tests_failed++; $display("FAIL dbg_read%0d: got valid=%b data=%h expected 1 %h", i, dbg_valid, dbg_data, exp_d[i]);
      end
    end
    dbg_req = 1'b0; dbg_addr = 5'd29;
    tick();
    tests_run++;
    if (dbg_valid !== 1'b0 || dbg_data !== 32'h0) begin
      tests_failed++; $display("FAIL dbg_end: got valid=%b data=%h expected 0 00000000", dbg_valid, dbg_data);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset   = 1'b1;
    rd_addr = '0;
    idle();
    #12;
    reset = 1'b0;
    #3;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_reservation();
    test_write_priority();
    test_debug();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_regfile_mp
